imm_gen_stage: RTL
==================

# imm_gen_stage

Registered, flow-controlled immediate generator for the decode stage. Each accepted 32-bit instruction word is classified by opcode into an immediate format, and its immediate is sign- or zero-extended to XLEN. The result is presented one cycle later through a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the fetch output register and decode/issue, and adds RV64 widening, an illegal-opcode flag, tag passthrough and pipeline flush.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- TAG_W, 32: width of the sideband tag (normally the PC) carried alongside each instruction.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drops all buffered entries and any same-cycle input
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept this cycle
- in_ir  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  format code (NONE/I/S/B/U/J/Z)
- out_tag  out  TAG_W  tag of head entry
- out_illegal  out  1  unsupported opcode or in_ir[1:0] != 2'b11

## Operation
- Format by opcode:
  - I: LOAD, ARITH_I, JALR, FENCE, SYSTEM.
  - I: ARITH_IW, only when XLEN=64; otherwise illegal.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - NONE: R-type (and R-type W when XLEN=64); imm=0.
- I/S/B/J immediates are sign-extended from IR[31] to XLEN; B and J have LSB=0.
- U immediate is {IR[31:12],12'b0}, sign-extended from bit 31 to XLEN.
- Illegal (any other opcode, or low bits != 11): out_illegal=1, fmt=NONE, imm=0. The entry is still delivered in order; it is never dropped.
- Shift-immediate encodings get a plain I-format immediate. Decode extracts the shamt.
- Buffer: 2 entries, FIFO order, each holding {imm, fmt, illegal, tag}.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- in_ready = (count != 2). It is derived from registered state only; there is no combinational path from out_ready.
- Count transitions:
  - Push with no pop: count+1.
  - Pop with no push: count-1.
  - Push and pop together (count=1): count stays 1, new entry becomes head next cycle.
  - Push and pop together (count=0): cannot occur; out_valid is 0 when empty.
- Priority: rst > flush > push/pop.
  - Flush: count <- 0 next edge. A same-cycle push is discarded; a same-cycle pop is irrelevant.

## Timing
- Latency: instruction accepted at edge N appears on out_* after edge N, when the buffer was empty. Throughput is 1 per cycle with out_ready held high.
- Reset values: out_valid=0, out_imm=0, out_fmt=NONE, out_tag=0, out_illegal=0, count=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Inputs are ignored while rst=1.
- rst or flush asserted mid-stream loses all buffered entries. There is no partial state.
- out_* are stable while out_valid && !out_ready. A valid entry is never withdrawn except by flush or rst.

## Configuration
- IMM_GEN_CSR_EN defined: SYSTEM with funct3 in {101,110,111} yields fmt=Z, imm = zero-extended IR[19:15].
- Not defined: all SYSTEM encodings yield I-format. The Z code is unused.

## Structure
- Shared package/defines holds:
  - opcode constants (incl. ARITH_IW, R_W, SYSTEM, FENCE);
  - format codes FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
- Sub-module imm_decode: purely combinational (in_ir -> imm, fmt, illegal), parameterised by XLEN.
- imm_gen_stage instantiates imm_decode and owns the skid buffer, which is two entry registers plus a 2-bit count.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=I, illegal=0.
- 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=B; XLEN=64, 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=U.
- out_ready=0, push tags 1,2,3 back-to-back:
  - in_ready drops after the second accept; tag 3 is held at the input;
  - raise out_ready -> tags out 1,2,3 in order, no duplicates.
- Buffer full (2 entries), flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the concurrent input never appears.
- 0x00000000 and 0x0000007F -> out_illegal=1, fmt=NONE, imm=0, delivered in order.
- 0x300FD073 (csrrwi x0,mstatus,31):
  - with IMM_GEN_CSR_EN: imm=0x1F, fmt=Z;
  - without: imm=0x300, fmt=I.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg
//   Shared constants for the immediate-generator stage: RV opcode values
//   (full 7-bit fields, so the low 2'b11 bits are part of every match)
//   and the 3-bit immediate format codes carried on out_fmt.
//   No ports; imported by imm_decode and imm_gen_stage.
package imm_gen_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_ARITH_I  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_ARITH_IW = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_ARITH_R  = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_R_W      = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if
//   Bundles the upstream (fetch) and downstream (decode/issue) handshakes of
//   the immediate-generator stage plus the pipeline flush.
//   Signals:
//     flush        drop all buffered entries and any same-cycle input
//     in_valid     instruction word present
//     in_ready     stage can accept this cycle
//     in_ir        32-bit instruction word
//     in_tag       sideband tag (normally the PC)
//     out_valid    head entry valid
//     out_ready    consumer takes head this cycle
//     out_imm      extended immediate, XLEN bits
//     out_fmt      format code (fmt_e)
//     out_tag      tag of head entry
//     out_illegal  unsupported opcode / bad low bits
//   Modports: master = surrounding pipeline, slave = the stage.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_ir;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_fmt;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_ir, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_ir, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage_imm_decode.sv
// imm_decode
//   Purely combinational opcode classifier and immediate extractor.
//   Ports:
//     i_ir       32-bit instruction word
//     o_imm      immediate, sign-extended (zero-extended for Z) to XLEN
//     o_fmt      format code (fmt_e)
//     o_illegal  opcode not supported at this XLEN, or low bits != 2'b11
//   Build option: IMM_GEN_CSR_EN decodes CSR immediate forms
//   (SYSTEM, funct3 = 101/110/111) as FMT_Z with the 5-bit uimm in rs1.
//   Shift-immediate encodings deliberately get the plain I immediate;
//   decode extracts shamt itself.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             i_ir,
  output logic signed [XLEN-1:0]  o_imm,
  output logic [2:0]              o_fmt,
  output logic                    o_illegal
);

  logic signed [XLEN-1:0] w_imm_i;
  logic signed [XLEN-1:0] w_imm_s;
  logic signed [XLEN-1:0] w_imm_b;
  logic signed [XLEN-1:0] w_imm_u;
  logic signed [XLEN-1:0] w_imm_j;

  // Size-casting a signed field replicates its MSB (IR[31]) up to XLEN.
  assign w_imm_i = XLEN'(signed'(i_ir[31:20]));
  assign w_imm_s = XLEN'(signed'({i_ir[31:25], i_ir[11:7]}));
  assign w_imm_b = XLEN'(signed'({i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0}));
  assign w_imm_u = XLEN'(signed'({i_ir[31:12], 12'b0}));
  assign w_imm_j = XLEN'(signed'({i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0}));

`ifdef IMM_GEN_CSR_EN
  logic signed [XLEN-1:0] w_imm_z;
  assign w_imm_z = signed'({{(XLEN-5){1'b0}}, i_ir[19:15]});
`endif

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (i_ir[6:0])
      OPC_LOAD, OPC_ARITH_I, OPC_JALR, OPC_FENCE: begin
        o_imm = w_imm_i;
        o_fmt = FMT_I;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        if (i_ir[14] && (i_ir[13:12] != 2'b00)) begin
          o_imm = w_imm_z;
          o_fmt = FMT_Z;
        end else begin
          o_imm = w_imm_i;
          o_fmt = FMT_I;
        end
`else
        o_imm = w_imm_i;
        o_fmt = FMT_I;
`endif
      end
      OPC_ARITH_IW: begin
        if (XLEN == 64) begin
          o_imm = w_imm_i;
          o_fmt = FMT_I;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        o_imm = w_imm_s;
        o_fmt = FMT_S;
      end
      OPC_BRANCH: begin
        o_imm = w_imm_b;
        o_fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_imm = w_imm_u;
        o_fmt = FMT_U;
      end
      OPC_JAL: begin
        o_imm = w_imm_j;
        o_fmt = FMT_J;
      end
      OPC_ARITH_R: begin
        o_fmt = FMT_NONE;
      end
      OPC_R_W: begin
        o_illegal = (XLEN != 64);
      end
      default: begin
        // Unknown opcode or low bits != 2'b11: flagged, imm=0, fmt=NONE.
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Registered, flow-controlled immediate generator for the decode stage.
//   Each accepted instruction is decoded by imm_decode and written into a
//   2-entry FIFO skid buffer; the head entry drives out_*.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (priority over flush)
//     bus   imm_gen_stage_if.slave (in_* / out_* handshakes, flush)
//   Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
//   Build option: IMM_GEN_CSR_EN (see imm_decode) enables FMT_Z results.
//   in_ready depends only on the registered count, so there is no
//   combinational path from out_ready to in_ready.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  imm_gen_stage_if.slave bus
);

  logic signed [XLEN-1:0] w_dec_imm;
  logic [2:0]             w_dec_fmt;
  logic                   w_dec_ill;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .i_ir      (bus.in_ir),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_ill)
  );

  logic [1:0]             r_cnt;
  logic signed [XLEN-1:0] r_e0_imm, r_e1_imm;
  logic [2:0]             r_e0_fmt, r_e1_fmt;
  logic                   r_e0_ill, r_e1_ill;
  logic [TAG_W-1:0]       r_e0_tag, r_e1_tag;

  logic w_out_valid;
  logic w_in_ready;
  logic w_push;
  logic w_pop;

  assign w_out_valid = (r_cnt != 2'd0);
  assign w_in_ready  = (r_cnt != 2'd2);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // ---- skid buffer occupancy: rst > flush > push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
    end else if (bus.flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---- skid buffer entries: entry 0 is always the head. Data is not reset;
  // stale contents are invisible because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      if (w_push) begin
        // Only reachable with one entry: the new word becomes head.
        r_e0_imm <= w_dec_imm;
        r_e0_fmt <= w_dec_fmt;
        r_e0_ill <= w_dec_ill;
        r_e0_tag <= bus.in_tag;
      end else begin
        r_e0_imm <= r_e1_imm;
        r_e0_fmt <= r_e1_fmt;
        r_e0_ill <= r_e1_ill;
        r_e0_tag <= r_e1_tag;
      end
    end else if (w_push) begin
      if (r_cnt == 2'd0) begin
        r_e0_imm <= w_dec_imm;
        r_e0_fmt <= w_dec_fmt;
        r_e0_ill <= w_dec_ill;
        r_e0_tag <= bus.in_tag;
      end else begin
        r_e1_imm <= w_dec_imm;
        r_e1_fmt <= w_dec_fmt;
        r_e1_ill <= w_dec_ill;
        r_e1_tag <= bus.in_tag;
      end
    end
  end

  // ---- output view of the head entry (all-zero while empty)
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_imm     = w_out_valid ? r_e0_imm : '0;
  assign bus.out_fmt     = w_out_valid ? r_e0_fmt : FMT_NONE;
  assign bus.out_illegal = w_out_valid ? r_e0_ill : 1'b0;
  assign bus.out_tag     = w_out_valid ? r_e0_tag : '0;

endmodule
